// File: rtl/ps2_key_decoder_if.sv
// Key-event bus between the PS/2 key decoder (master) and the VGA/game
// controller (slave). Carries the decoded scan code plus its strobes.
interface ps2_key_decoder_if;
    logic [7:0] key_code;     // last decoded byte, prefixes stripped
    logic       key_en;       // one-cycle make strobe
    logic       key_ext;      // key_code came with an E0 prefix
    logic       key_release;  // one-cycle break strobe
    logic       frame_err;    // one-cycle framing/parity/timeout strobe

    modport master (
        output key_code,
        output key_en,
        output key_ext,
        output key_release,
        output frame_err
    );

    modport slave (
        input key_code,
        input key_en,
        input key_ext,
        input key_release,
        input frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Synchronises and glitch-filters the PS/2 lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and folds E0/F0 prefixes into
// key_ext / key_release on the key-event bus.
// Optional build macro TYPEMATIC_FILTER_EN: suppresses auto-repeated makes
// of the key that is already held down.
module ps2_key_decoder #(
    parameter int SYNC_STAGES = 2,      // must be >= 2
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_key_decoder_if.master  key_if
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    // Bring both asynchronous pad lines into the iVGA_CLK domain.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours and the chain shifts by one stage.
    // NOTE: the synchronisers reset to 1, the idle level of an open-drain
    // PS/2 line, so leaving reset never looks like a falling clock edge.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock glitch filter and falling-edge detect
    // ------------------------------------------------------------------
    logic           clk_filt;
    logic           clk_filt_q;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    // Accept a new clock level only after FILTER_LEN consecutive samples agree.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_q <= clk_filt;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_q & ~clk_filt;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state, state_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic [7:0]     shift, shift_d;
    logic           par_err, par_err_d;
    logic [TCW-1:0] tmo_cnt, tmo_cnt_d;
    logic           byte_vld, byte_vld_d;
    logic           frame_err_q, err_d;

    // Register the frame state, bit counter, shift register and timeout.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_err     <= 1'b0;
            tmo_cnt     <= '0;
            byte_vld    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            shift       <= shift_d;
            par_err     <= par_err_d;
            tmo_cnt     <= tmo_cnt_d;
            byte_vld    <= byte_vld_d;
            frame_err_q <= err_d;
        end
    end

    // Advance the frame on each accepted falling edge, or abort on timeout.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        par_err_d  = par_err;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        tmo_cnt_d  = (fall || state == IDLE) ? '0 : tmo_cnt + 1'b1;

        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;           // bad start bit
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    // Data ones plus parity bit must be odd.
                    par_err_d = ~(^shift ^ data_s);
                    state_d   = STOP;
                end
                STOP: begin
                    if (data_s && !par_err) byte_vld_d = 1'b1;
                    else                    err_d      = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TCW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;                     // partial byte dropped
            err_d   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decode
    // ------------------------------------------------------------------
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_en_q;
    logic       key_rel_q;
    logic       ext_flag;
    logic       brk_flag;

`ifdef TYPEMATIC_FILTER_EN
    logic       last_vld;
    logic       last_ext;
    logic [7:0] last_code;
    logic       last_hit;

    assign last_hit = last_vld && (last_ext == ext_flag) && (last_code == shift);
`endif

    // Fold E0/F0 prefixes into flags and emit one event per final byte.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_code_q <= '0;
            key_ext_q  <= 1'b0;
            key_en_q   <= 1'b0;
            key_rel_q  <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_vld   <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= '0;
`endif
        end else begin
            key_en_q  <= 1'b0;
            key_rel_q <= 1'b0;
            if (frame_err_q) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_vld) begin
                if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                    if (brk_flag) begin
                        key_code_q <= shift;
                        key_ext_q  <= ext_flag;
                        key_rel_q  <= 1'b1;
                        if (last_hit) last_vld <= 1'b0;
                    end else if (!last_hit) begin
                        // Auto-repeat of the held key falls through silently.
                        key_code_q <= shift;
                        key_ext_q  <= ext_flag;
                        key_en_q   <= 1'b1;
                        last_vld   <= 1'b1;
                        last_ext   <= ext_flag;
                        last_code  <= shift;
                    end
`else
                    key_code_q <= shift;
                    key_ext_q  <= ext_flag;
                    if (brk_flag) key_rel_q <= 1'b1;
                    else          key_en_q  <= 1'b1;
`endif
                end
            end
        end
    end

    assign key_if.key_code    = key_code_q;
    assign key_if.key_ext     = key_ext_q;
    assign key_if.key_en      = key_en_q;
    assign key_if.key_release = key_rel_q;
    assign key_if.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a table of single frames with
// expected event counts and key state, plus directed sequences for latency,
// clock glitch, mid-frame reset, timeout and typematic repeat.
module tb_ps2_key_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 8;
    localparam int TMO  = 50000;
    localparam int H    = 20;   // PS/2 half-bit, in iVGA_CLK cycles

    logic iVGA_CLK = 1'b0;
    logic iRST_n;
    logic ps2_clk;
    logic ps2_data;

    ps2_key_decoder_if kif ();

    ps2_key_decoder #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_if   (kif)
    );

    always #20 iVGA_CLK = ~iVGA_CLK;

    int cyc = 0;
    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge of iVGA_CLK.
    int en_cnt = 0, rel_cnt = 0, err_cnt = 0, both_cnt = 0;
    int en_cyc = 0, err_cyc = 0;
    always @(negedge iVGA_CLK) begin
        if (kif.key_en)      begin en_cnt  <= en_cnt + 1;  en_cyc  <= cyc; end
        if (kif.key_release) rel_cnt <= rel_cnt + 1;
        if (kif.frame_err)   begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
        if (kif.key_en && kif.key_release) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int last_fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge iVGA_CLK);
    endtask

    // Send up to n_edges bits of a frame; optional parity/stop corruption and
    // a one-cycle low glitch on ps2_clk during the high phase of bit 3.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int n_edges, input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n_edges; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 3) begin
                wait_cyc(H / 2);
                ps2_clk = 1'b0;
                wait_cyc(1);
                ps2_clk = 1'b1;
                wait_cyc(H - H / 2 - 1);
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " key_code"},    32'(kif.key_code),    32'h0);
        check({tag, " key_ext"},     32'(kif.key_ext),     32'h0);
        check({tag, " key_en"},      32'(kif.key_en),      32'h0);
        check({tag, " key_release"}, 32'(kif.key_release), 32'h0);
        check({tag, " frame_err"},   32'(kif.frame_err),   32'h0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         en;
        int         rel;
        int         err;
        logic [7:0] code;
        bit         ext;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        int e0, r0, x0;

        vecs[0]  = '{8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0};
        vecs[1]  = '{8'hE0, 0, 0, 0, 0, 0, 8'h1C, 0};
        vecs[2]  = '{8'h6B, 0, 0, 1, 0, 0, 8'h6B, 1};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 0, 8'h6B, 1};
        vecs[4]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h6B, 1};
        vecs[5]  = '{8'h74, 0, 0, 0, 1, 0, 8'h74, 1};
        vecs[6]  = '{8'h1C, 1, 0, 0, 0, 1, 8'h74, 1};
        vecs[7]  = '{8'h1C, 0, 0, 1, 0, 0, 8'h1C, 0};
        vecs[8]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0};
        vecs[9]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0};
        vecs[10] = '{8'hE0, 0, 0, 0, 0, 0, 8'h1C, 0};
        vecs[11] = '{8'hF0, 0, 1, 0, 0, 1, 8'h1C, 0};
        vecs[12] = '{8'h75, 0, 0, 1, 0, 0, 8'h75, 0};
        vecs[13] = '{8'hE1, 0, 0, 1, 0, 0, 8'hE1, 0};

        iRST_n   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(4);
        check_outputs_zero("reset");
        iRST_n = 1'b1;
        wait_cyc(4);

        // Table-driven single frames.
        for (int i = 0; i < NV; i++) begin
            e0 = en_cnt; r0 = rel_cnt; x0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11, 1'b0);
            check($sformatf("vec%0d key_en count", i),      32'(en_cnt - e0),  32'(vecs[i].en));
            check($sformatf("vec%0d key_release count", i), 32'(rel_cnt - r0), 32'(vecs[i].rel));
            check($sformatf("vec%0d frame_err count", i),   32'(err_cnt - x0), 32'(vecs[i].err));
            check($sformatf("vec%0d key_code", i),          32'(kif.key_code), 32'(vecs[i].code));
            check($sformatf("vec%0d key_ext", i),           32'(kif.key_ext),  32'(vecs[i].ext));
        end

        // Latency from raw stop-bit falling edge to key_en.
        e0 = en_cnt;
        send_frame(8'h5A, 0, 0, 11, 1'b0);
        check("latency key_en count", 32'(en_cnt - e0), 32'd1);
        check("latency cycles", 32'(en_cyc - last_fall_cyc), 32'(FILT + SYNC + 2));
        check("latency key_code", 32'(kif.key_code), 32'h5A);

        // One-cycle clock glitch inside a frame is ignored.
        e0 = en_cnt; x0 = err_cnt;
        send_frame(8'h2A, 0, 0, 11, 1'b1);
        check("glitch key_en count", 32'(en_cnt - e0), 32'd1);
        check("glitch frame_err count", 32'(err_cnt - x0), 32'd0);
        check("glitch key_code", 32'(kif.key_code), 32'h2A);

        // Reset mid-frame after an E0 prefix: outputs and flags cleared.
        send_frame(8'hE0, 0, 0, 11, 1'b0);
        send_frame(8'h33, 0, 0, 4, 1'b0);
        iRST_n = 1'b0;
        wait_cyc(3);
        check_outputs_zero("mid-frame reset");
        iRST_n = 1'b1;
        wait_cyc(4);
        e0 = en_cnt; x0 = err_cnt;
        send_frame(8'h29, 0, 0, 11, 1'b0);
        check("post-reset key_en count", 32'(en_cnt - e0), 32'd1);
        check("post-reset frame_err count", 32'(err_cnt - x0), 32'd0);
        check("post-reset key_code", 32'(kif.key_code), 32'h29);
        check("post-reset key_ext", 32'(kif.key_ext), 32'd0);

        // Clock stalls after start + 5 data bits: timeout, then recovery.
        x0 = err_cnt; e0 = en_cnt;
        send_frame(8'h72, 0, 0, 6, 1'b0);
        for (int i = 0; i < TMO + 200 && err_cnt == x0; i++) @(negedge iVGA_CLK);
        wait_cyc(2);
        check("timeout frame_err count", 32'(err_cnt - x0), 32'd1);
        check("timeout cycles", 32'(err_cyc - last_fall_cyc), 32'(TMO + SYNC + FILT + 1));
        check("timeout no key_en", 32'(en_cnt - e0), 32'd0);
        send_frame(8'h72, 0, 0, 11, 1'b0);
        check("after timeout key_en count", 32'(en_cnt - e0), 32'd1);
        check("after timeout key_code", 32'(kif.key_code), 32'h72);
        check("after timeout key_ext", 32'(kif.key_ext), 32'd0);

        // Held right-arrow: E0,74 three times, then release and press again.
        e0 = en_cnt;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hE0, 0, 0, 11, 1'b0);
            send_frame(8'h74, 0, 0, 11, 1'b0);
        end
`ifdef TYPEMATIC_FILTER_EN
        check("repeat key_en count", 32'(en_cnt - e0), 32'd1);
`else
        check("repeat key_en count", 32'(en_cnt - e0), 32'd3);
`endif
        check("repeat key_code", 32'(kif.key_code), 32'h74);
        check("repeat key_ext", 32'(kif.key_ext), 32'd1);

        e0 = en_cnt; r0 = rel_cnt;
        send_frame(8'hE0, 0, 0, 11, 1'b0);
        send_frame(8'hF0, 0, 0, 11, 1'b0);
        send_frame(8'h74, 0, 0, 11, 1'b0);
        check("arrow release count", 32'(rel_cnt - r0), 32'd1);
        check("arrow release no key_en", 32'(en_cnt - e0), 32'd0);
        send_frame(8'hE0, 0, 0, 11, 1'b0);
        send_frame(8'h74, 0, 0, 11, 1'b0);
        check("re-press key_en count", 32'(en_cnt - e0), 32'd1);
        check("re-press key_code", 32'(kif.key_code), 32'h74);

        check("key_en and key_release never together", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
